// File: rtl/axis_uart_bridge_pkg.sv
// Shared types and helpers for the AXIS UART frame checker: FSM state encoding
// and the byte-wise XOR checksum.
package axis_uart_bridge_pkg;

  typedef enum logic [0:0] {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } frame_state_e;

  localparam int unsigned MaxBytes = 64;

  // Callers zero-extend; zero bytes do not change an XOR, so all lanes are folded.
  function automatic logic [7:0] xor_bytes(input logic [MaxBytes*8-1:0] data);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      acc = acc ^ data[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/axis_uart_frame_skid.sv
// Two-entry output skid buffer; in_ready_o is registered and high while fewer
// than two entries are held.
module axis_uart_frame_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          rdy_q, rdy_d;
  logic          pop;

  assign pop = (cnt_q != 2'd0) && out_ready_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (in_valid_i && !pop) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd0) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
    end else if (pop && !in_valid_i) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
      end
    end else if (pop && in_valid_i) begin
      // Occupancy unchanged: the new word lands behind whatever remains.
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = in_data_i;
      end else begin
        head_d = in_data_i;
      end
    end
    rdy_d = (cnt_d < 2'd2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;

endmodule

// File: rtl/axis_uart_frame_checker.sv
// Validates one-word UART frames (sync, sequence, payload, XOR) and forwards good ones.
// Optional statistics ports GOOD_CNT/BAD_CNT under AXIS_UART_FRAME_CHECKER_STAT_EN.
module axis_uart_frame_checker
  import axis_uart_bridge_pkg::*;
#(
  parameter int unsigned N_BYTES    = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'h5A,
  parameter int unsigned LOST_LIMIT = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_BYTES*8-1:0]     S_AXIS_TDATA,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  output logic [(N_BYTES-3)*8-1:0] M_AXIS_TDATA,
  output logic [7:0]               M_AXIS_TUSER,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic                     ERR_SYNC,
  output logic                     ERR_CSUM,
  output logic                     ERR_SEQ,
  output logic                     LOCKED
`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]     GOOD_CNT,
  output logic [CNT_WIDTH-1:0]     BAD_CNT
`endif
);

  localparam int unsigned PayW = (N_BYTES - 3) * 8;
  localparam int unsigned SkidW = PayW + 8;

  frame_state_e state_q, state_d;
  logic [7:0]   exp_seq_q, exp_seq_d;
  logic [7:0]   bad_run_q, bad_run_d;
  logic         err_sync_q, err_sync_d;
  logic         err_csum_q, err_csum_d;
  logic         err_seq_q, err_seq_d;

  logic             in_ready;
  logic             accept;
  logic             sync_bad;
  logic             csum_bad;
  logic             good;
  logic [7:0]       rx_seq;
  logic [7:0]       calc_csum;
  logic [SkidW-1:0] skid_out;

  assign rx_seq    = S_AXIS_TDATA[15:8];
  assign calc_csum = xor_bytes((MaxBytes*8)'(S_AXIS_TDATA[(N_BYTES-1)*8-1:0]));
  assign sync_bad  = (S_AXIS_TDATA[7:0] != SYNC_BYTE);
  assign csum_bad  = (S_AXIS_TDATA[N_BYTES*8-1 -: 8] != calc_csum);
  assign accept    = S_AXIS_TVALID && in_ready;
  assign good      = accept && !sync_bad && !csum_bad;

  always_comb begin
    state_d    = state_q;
    exp_seq_d  = exp_seq_q;
    bad_run_d  = bad_run_q;
    err_sync_d = accept && sync_bad;
    err_csum_d = accept && csum_bad;
    err_seq_d  = 1'b0;
    if (good) begin
      err_seq_d = (state_q == StLocked) && (rx_seq != exp_seq_q);
      exp_seq_d = rx_seq + 8'd1;
      bad_run_d = 8'd0;
      state_d   = StLocked;
    end else if (accept && state_q == StLocked) begin
      if (bad_run_q + 8'd1 >= 8'(LOST_LIMIT)) begin
        state_d   = StHunt;
        bad_run_d = 8'd0;
      end else begin
        bad_run_d = bad_run_q + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StHunt;
      exp_seq_q  <= 8'd0;
      bad_run_q  <= 8'd0;
      err_sync_q <= 1'b0;
      err_csum_q <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_seq_q  <= exp_seq_d;
      bad_run_q  <= bad_run_d;
      err_sync_q <= err_sync_d;
      err_csum_q <= err_csum_d;
      err_seq_q  <= err_seq_d;
    end
  end

  axis_uart_frame_skid #(
    .DW (SkidW)
  ) u_skid (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_valid_i  (good),
    .in_data_i   ({rx_seq, S_AXIS_TDATA[(N_BYTES-1)*8-1:16]}),
    .in_ready_o  (in_ready),
    .out_valid_o (M_AXIS_TVALID),
    .out_data_o  (skid_out),
    .out_ready_i (M_AXIS_TREADY)
  );

  assign S_AXIS_TREADY = in_ready;
  assign M_AXIS_TUSER  = skid_out[SkidW-1 -: 8];
  assign M_AXIS_TDATA  = skid_out[PayW-1:0];
  assign ERR_SYNC      = err_sync_q;
  assign ERR_CSUM      = err_csum_q;
  assign ERR_SEQ       = err_seq_q;
  assign LOCKED        = (state_q == StLocked);

`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (good && !(&good_cnt_q)) begin
      good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
    end
    if (accept && !good && !(&bad_cnt_q)) begin
      bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign GOOD_CNT = good_cnt_q;
  assign BAD_CNT  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_axis_uart_frame_checker.sv
// Table-driven bench for axis_uart_frame_checker (N_BYTES=4, LOST_LIMIT=4) with an
// output scoreboard; statistics checks only when AXIS_UART_FRAME_CHECKER_STAT_EN is set.
module tb_axis_uart_frame_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        err_sync, err_csum, err_seq, locked;
`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
  logic [31:0] good_cnt, bad_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n_good = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] user;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] word;
    bit fwd, e_sync, e_csum, e_seq, e_lock;
  } vec_t;
  vec_t tbl[19];

  always #5 aclk = ~aclk;

  axis_uart_frame_checker #(
    .N_BYTES    (4),
    .SYNC_BYTE  (8'h5A),
    .LOST_LIMIT (4),
    .CNT_WIDTH  (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .ERR_SYNC      (err_sync),
    .ERR_CSUM      (err_csum),
    .ERR_SEQ       (err_seq),
    .LOCKED        (locked)
`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
    ,
    .GOOD_CNT      (good_cnt),
    .BAD_CNT       (bad_cnt)
`endif
  );

  function automatic logic [31:0] mk(input logic [7:0] s, input logic [7:0] q,
                                     input logic [7:0] p, input bit corrupt);
    logic [7:0] c;
    c = s ^ q ^ p;
    if (corrupt) c = ~c;
    return {c, p, q, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected frame.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {m_tuser, m_tdata}, 16'hxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_user", {24'd0, m_tuser}, {24'd0, e.user});
        chk("out_data", {24'd0, m_tdata}, {24'd0, e.data});
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit fwd, input bit es, input bit ec,
                      input bit eq, input bit el, input bit chk_out);
    int n;
    @(posedge aclk);
    #1;
    s_tdata  = w;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    if (fwd) begin
      sb.push_back('{user: w[15:8], data: w[23:16]});
      n_good++;
    end else begin
      n_bad++;
    end
    @(negedge aclk);
    chk("err_sync", {31'd0, err_sync}, {31'd0, es});
    chk("err_csum", {31'd0, err_csum}, {31'd0, ec});
    chk("err_seq", {31'd0, err_seq}, {31'd0, eq});
    chk("locked", {31'd0, locked}, {31'd0, el});
    if (chk_out) chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, fwd});
    @(negedge aclk);
    chk("err_pulse_width", {29'd0, err_sync, err_csum, err_seq}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{mk(8'h5A, 8'h07, 8'h33, 0), 1, 0, 0, 0, 1};
    tbl[1]  = '{mk(8'h5B, 8'h08, 8'h11, 0), 0, 1, 0, 0, 1};
    tbl[2]  = '{mk(8'h5A, 8'h08, 8'h22, 0), 1, 0, 0, 0, 1};
    tbl[3]  = '{mk(8'h5A, 8'h04, 8'h44, 0), 1, 0, 0, 1, 1};
    tbl[4]  = '{mk(8'h5A, 8'h09, 8'h55, 0), 1, 0, 0, 1, 1};
    tbl[5]  = '{mk(8'h5A, 8'h0A, 8'h66, 0), 1, 0, 0, 0, 1};
    tbl[6]  = '{mk(8'h5A, 8'h0B, 8'h77, 1), 0, 0, 1, 0, 1};
    tbl[7]  = '{mk(8'h5A, 8'h0B, 8'h77, 1), 0, 0, 1, 0, 1};
    tbl[8]  = '{mk(8'h5A, 8'h0B, 8'h77, 1), 0, 0, 1, 0, 1};
    tbl[9]  = '{mk(8'h5A, 8'h0B, 8'h88, 0), 1, 0, 0, 0, 1};
    tbl[10] = '{mk(8'h5A, 8'h0C, 8'h99, 1), 0, 0, 1, 0, 1};
    tbl[11] = '{mk(8'h5A, 8'h0C, 8'h99, 1), 0, 0, 1, 0, 1};
    tbl[12] = '{mk(8'h5A, 8'h0C, 8'h99, 1), 0, 0, 1, 0, 1};
    tbl[13] = '{mk(8'h5A, 8'h0C, 8'h99, 1), 0, 0, 1, 0, 0};
    tbl[14] = '{mk(8'h5B, 8'h0C, 8'hAA, 0), 0, 1, 0, 0, 0};
    tbl[15] = '{mk(8'h5A, 8'h20, 8'hBB, 0), 1, 0, 0, 0, 1};
    tbl[16] = '{mk(8'h5A, 8'hFF, 8'hCC, 0), 1, 0, 0, 1, 1};
    tbl[17] = '{mk(8'h5A, 8'h00, 8'hDD, 0), 1, 0, 0, 0, 1};
    tbl[18] = '{mk(8'h5B, 8'h01, 8'hEE, 1), 0, 1, 1, 0, 1};

    // Reset state
    #12;
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_out", {16'd0, m_tuser, m_tdata}, 32'd0);
    chk("rst_errs_locked", {28'd0, err_sync, err_csum, err_seq, locked}, 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_release_0", {31'd0, s_tready}, 32'd0);
    @(negedge aclk);
    chk("tready_after_release_1", {31'd0, s_tready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      send(tbl[i].word, tbl[i].fwd, tbl[i].e_sync, tbl[i].e_csum, tbl[i].e_seq,
           tbl[i].e_lock, 1);
    end

    // Backpressure: two frames buffered, third stalls until the sink drains.
    m_tready = 1'b0;
    send(mk(8'h5A, 8'h01, 8'h61, 0), 1, 0, 0, 0, 1, 0);
    send(mk(8'h5A, 8'h02, 8'h62, 0), 1, 0, 0, 0, 1, 0);
    fork
      send(mk(8'h5A, 8'h03, 8'h63, 0), 1, 0, 0, 0, 1, 0);
      begin
        repeat (3) @(negedge aclk);
        chk("full_s_tready", {31'd0, s_tready}, 32'd0);
        chk("stall_m_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_m_hold", {16'd0, m_tuser, m_tdata}, 32'h0161);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    repeat (4) @(negedge aclk);
    chk("drain_sb_empty", sb.size(), 32'd0);

`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
    chk("good_cnt", good_cnt, n_good);
    chk("bad_cnt", bad_cnt, n_bad);
`endif

    // Reset with two frames buffered
    m_tready = 1'b0;
    send(mk(8'h5A, 8'h04, 8'h71, 0), 1, 0, 0, 0, 1, 0);
    send(mk(8'h5A, 8'h05, 8'h72, 0), 1, 0, 0, 0, 1, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mid_rst_m_out", {16'd0, m_tuser, m_tdata}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
`ifdef AXIS_UART_FRAME_CHECKER_STAT_EN
    chk("rst_good_cnt", good_cnt, 32'd0);
    chk("rst_bad_cnt", bad_cnt, 32'd0);
`endif
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_tready = 1'b1;
    @(negedge aclk);
    chk("rerelease_tready_0", {31'd0, s_tready}, 32'd0);
    @(negedge aclk);
    chk("rerelease_tready_1", {31'd0, s_tready}, 32'd1);
    repeat (4) @(negedge aclk);
    chk("post_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("post_rst_locked", {31'd0, locked}, 32'd0);

    // Fresh lock from HUNT: no sequence error regardless of value
    send(mk(8'h5A, 8'h30, 8'h81, 0), 1, 0, 0, 0, 1, 1);
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge aclk);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_uart_frame_checker.md
AXIS_UART_FRAME_CHECKER -- requirements
Module: axis_uart_frame_checker

Interface
REQ-001 SHALL have parameter N_BYTES, default 32: input word width in bytes, legal range 4..64.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'h5A: required value of frame byte 0.
REQ-003 SHALL have parameter LOST_LIMIT, default 4: consecutive bad frames that force HUNT, legal range 1..255.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: statistics counter width.
REQ-005 SHALL have port aclk, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port S_AXIS_TDATA, input, N_BYTES*8: word from the UART bridge RX side; byte k = bits [8k+7:8k].
REQ-008 SHALL have ports S_AXIS_TVALID (input, 1) and S_AXIS_TREADY (output, 1): AXIS handshake.
REQ-009 SHALL have port M_AXIS_TDATA, output, (N_BYTES-3)*8: payload bytes 2..N_BYTES-2, in order.
REQ-010 SHALL have port M_AXIS_TUSER, output, 8: received sequence byte (byte 1).
REQ-011 SHALL have ports M_AXIS_TVALID (output, 1) and M_AXIS_TREADY (input, 1): AXIS handshake.
REQ-012 SHALL have outputs ERR_SYNC, ERR_CSUM, ERR_SEQ (1 each): one-cycle error pulses; LOCKED (1): state is LOCKED.

Function
REQ-013 Frame layout SHALL be: byte 0 = SYNC_BYTE, byte 1 = sequence, bytes 2..N-2 = payload, byte N-1 = XOR of bytes 0..N-2.
REQ-014 A word SHALL be accepted only on S_AXIS_TVALID && S_AXIS_TREADY; one word = one frame.
REQ-015 Bad frame = byte 0 != SYNC_BYTE (ERR_SYNC pulse) or checksum mismatch (ERR_CSUM pulse); both pulses may fire together; bad frames SHALL be dropped.
REQ-016 Good frame SHALL be forwarded; M_AXIS_TVALID SHALL assert the cycle after acceptance (latency 1) when the output is empty.
REQ-017 Output SHALL be a 2-entry skid buffer: S_AXIS_TREADY registered, high while fewer than 2 entries are held; M_AXIS data stable while TVALID && !TREADY.
REQ-018 Simultaneous input accept and output pop SHALL keep occupancy unchanged; no frame lost or duplicated.
REQ-019 FSM states: HUNT (reset state) and LOCKED.
REQ-020 HUNT -> LOCKED on a good frame; expected sequence := received + 1 (mod 256); no ERR_SEQ in HUNT.
REQ-021 In LOCKED, a good frame with sequence != expected SHALL pulse ERR_SEQ, still be forwarded, and set expected := received + 1.
REQ-022 In LOCKED, a bad-frame run counter SHALL increment per bad frame and clear on a good frame; reaching LOST_LIMIT SHALL force HUNT and clear the counter.
REQ-023 Sequence wrap 8'hFF -> 8'h00 SHALL be treated as in-order.

Reset
REQ-024 While aresetn low: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TUSER=0, all ERR_* =0, LOCKED=0, state HUNT, buffer empty, counters 0.
REQ-025 Reset mid-frame SHALL discard buffered frames; S_AXIS_TREADY SHALL rise one cycle after aresetn deasserts.

Configuration
REQ-026 With AXIS_UART_FRAME_CHECKER_STAT_EN defined: outputs GOOD_CNT and BAD_CNT (CNT_WIDTH each) count good/bad frames, saturating at all-ones, reset to 0.
REQ-027 Without AXIS_UART_FRAME_CHECKER_STAT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package axis_uart_bridge_pkg SHALL hold the FSM state enum (HUNT, LOCKED) and the XOR-reduce checksum function.
REQ-029 Skid buffer SHALL be sub-module axis_uart_frame_skid, parameterised by data width.

Verification
REQ-030 N_BYTES=4: word {csum=5A^07^33, 33, 07, 5A} -> M_AXIS_TDATA=8'h33, TUSER=8'h07, LOCKED=1 next cycle.
REQ-031 Byte 0 = 8'h5B with correct XOR -> ERR_SYNC one-cycle pulse, no M_AXIS_TVALID, BAD_CNT=1 (STAT_EN).
REQ-032 LOCKED, expected seq 8'h05, good frame seq 8'h09 -> ERR_SEQ pulse, frame forwarded, next seq 8'h0A accepted silently.
REQ-033 LOCKED, 4 consecutive corrupt checksums (LOST_LIMIT=4) -> LOCKED drops after 4th accept; 3 bad then 1 good stays LOCKED.
REQ-034 M_AXIS_TREADY held 0, 3 good frames offered -> 2 buffered, S_AXIS_TREADY=0, then TREADY=1 -> all 3 emerge in order.
REQ-035 aresetn pulsed low with 2 frames buffered -> all outputs zero, nothing emitted after release, LOCKED=0.
